// File: rtl/ibex_rf_write_sched_pkg.sv
// Shared definitions for the register-file write scheduler: the wipe FSM
// states and the register-count constants.
package ibex_rf_write_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIPE = 2'd1,
    DONE = 2'd2
  } wipe_state_e;

  localparam int unsigned NumWordsRv32i = 32;
  localparam int unsigned NumWordsRv32e = 16;

  // Address and valid of the write to be registered onto the write port.
  typedef struct packed {
    logic       vld;
    logic [4:0] addr;
  } wr_req_t;

  function automatic int unsigned num_words(bit rv32e);
    return rv32e ? NumWordsRv32e : NumWordsRv32i;
  endfunction

endpackage

// File: rtl/ibex_rf_onehot_dec.sv
// One-hot write-enable decode. x0 and registers beyond the implemented count
// can never be enabled.
module ibex_rf_onehot_dec #(
  parameter int unsigned NumWords = 32
) (
  input  logic [4:0]  addr_i,
  input  logic        en_i,
  output logic [31:0] onehot_o
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    if (i == 0 || i >= NumWords) begin : g_zero
      assign onehot_o[i] = 1'b0;
    end else begin : g_dec
      assign onehot_o[i] = en_i & (addr_i == 5'(i));
    end
  end

endmodule

// File: rtl/ibex_rf_write_sched.sv
// Register-file write scheduler: round-robin between EX and LSU writeback,
// plus a wipe sequence that zeroes x1..xN-1 through the same write path.
module ibex_rf_write_sched
  import ibex_rf_write_sched_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_req_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_gnt_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  input  logic                 wipe_req_i,
  output logic                 wipe_busy_o,
  output logic                 wipe_done_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic [31:0]          write_enable_secure_o
);

  localparam int unsigned NumWords = num_words(RV32E);
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

  wipe_state_e          state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;  // 1: LSU served last
  wr_req_t              wr;
  logic [4:0]           wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 we_q;
  logic                 done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ex_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    wr           = '0;
    wr_data      = '0;
    unique case (state_q)
      IDLE: begin
        if (wipe_req_i) begin
          cnt_d   = 5'd1;
          state_d = WIPE;
        end else if (lsu_req_i && (!ex_req_i || !last_grant_q)) begin
          lsu_gnt_o    = 1'b1;
          wr           = '{vld: 1'b1, addr: lsu_addr_i};
          wr_data      = lsu_wdata_i;
          last_grant_d = 1'b1;
        end else if (ex_req_i) begin
          ex_gnt_o     = 1'b1;
          wr           = '{vld: 1'b1, addr: ex_addr_i};
          wr_data      = ex_wdata_i;
          last_grant_d = 1'b0;
        end
      end
      WIPE: begin
        wr = '{vld: 1'b1, addr: cnt_q};
        if (cnt_q == LastAddr) state_d = DONE;
        else                   cnt_d   = cnt_q + 5'd1;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RV32E has only 16 registers, so bit 4 is dropped before decode.
  assign wr_addr = RV32E ? {1'b0, wr.addr[3:0]} : wr.addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      if (wr.vld) begin
        waddr_q <= wr_addr;
        wdata_q <= wr_data;
      end
      we_q   <= wr.vld && (wr_addr != 5'd0);
      done_q <= (state_d == DONE);
    end
  end

  assign waddr_a_o   = waddr_q;
  assign wdata_a_o   = wdata_q;
  assign we_a_o      = we_q;
  assign wipe_done_o = done_q;
  assign wipe_busy_o = (state_q != IDLE);

  ibex_rf_onehot_dec #(.NumWords(NumWords)) u_dec (
    .addr_i   (waddr_q),
    .en_i     (we_q),
    .onehot_o (write_enable_secure_o)
  );

endmodule

// File: tb/tb_ibex_rf_write_sched.sv
// Directed bench: RV32I instance for arbitration/wipe/reset, RV32E instance
// for the reduced register count and address masking.
module tb_ibex_rf_write_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_req_i, lsu_req_i, wipe_req_i;
  logic [4:0]  ex_addr_i, lsu_addr_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;

  logic        ex_gnt, lsu_gnt, busy, done, we;
  logic [4:0]  waddr;
  logic [31:0] wdata, sec;
  logic        ex_gnt_e, lsu_gnt_e, busy_e, done_e, we_e;
  logic [4:0]  waddr_e;
  logic [31:0] wdata_e, sec_e;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_write_sched #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_req_i(ex_req_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_gnt_o(ex_gnt),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt),
    .wipe_req_i(wipe_req_i), .wipe_busy_o(busy), .wipe_done_o(done),
    .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we), .write_enable_secure_o(sec)
  );

  ibex_rf_write_sched #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_req_i(ex_req_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_gnt_o(ex_gnt_e),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_e),
    .wipe_req_i(wipe_req_i), .wipe_busy_o(busy_e), .wipe_done_o(done_e),
    .waddr_a_o(waddr_e), .wdata_a_o(wdata_e), .we_a_o(we_e), .write_enable_secure_o(sec_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn, bz;
    logic [31:0] oh;
    rst_i = 1'b1; ex_req_i = 0; lsu_req_i = 0; wipe_req_i = 0;
    ex_addr_i = 0; lsu_addr_i = 0; ex_wdata_i = 0; lsu_wdata_i = 0;
    tick(); tick();
    smp();
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_sec", sec, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // Arbitration after reset: LSU first, then EX
    tick(); rst_i = 1'b0;
    ex_req_i = 1; ex_addr_i = 5; ex_wdata_i = 32'h55;
    lsu_req_i = 1; lsu_addr_i = 6; lsu_wdata_i = 32'h66;
    smp();
    chk("arb0_lsu_gnt", 32'(lsu_gnt), 1);
    chk("arb0_ex_gnt", 32'(ex_gnt), 0);
    tick(); lsu_req_i = 0;
    smp();
    chk("arb1_we", 32'(we), 1);
    chk("arb1_waddr", 32'(waddr), 6);
    chk("arb1_wdata", wdata, 32'h66);
    chk("arb1_sec", sec, 32'h40);
    chk("arb1_ex_gnt", 32'(ex_gnt), 1);
    chk("arb1_lsu_gnt", 32'(lsu_gnt), 0);
    tick(); ex_req_i = 0;
    smp();
    chk("arb2_waddr", 32'(waddr), 5);
    chk("arb2_sec", sec, 32'h20);

    // Round robin: LSU alone, then both -> EX, then LSU again
    tick(); lsu_req_i = 1; lsu_addr_i = 3; lsu_wdata_i = 32'h33;
    smp();
    chk("rr0_lsu_gnt", 32'(lsu_gnt), 1);
    tick(); ex_req_i = 1; ex_addr_i = 4; ex_wdata_i = 32'h34; lsu_addr_i = 7; lsu_wdata_i = 32'h77;
    smp();
    chk("rr1_ex_gnt", 32'(ex_gnt), 1);
    chk("rr1_lsu_gnt", 32'(lsu_gnt), 0);
    chk("rr1_waddr", 32'(waddr), 3);
    chk("rr1_sec", sec, 32'h8);
    tick(); ex_req_i = 0;
    smp();
    chk("rr2_lsu_gnt", 32'(lsu_gnt), 1);
    chk("rr2_waddr", 32'(waddr), 4);
    chk("rr2_wdata", wdata, 32'h34);
    tick(); lsu_req_i = 0;
    smp();
    chk("rr3_waddr", 32'(waddr), 7);

    // Address bit 4: honoured on RV32I, dropped on RV32E
    tick(); lsu_req_i = 1; lsu_addr_i = 5'h13; lsu_wdata_i = 32'h13;
    smp();
    chk("b4_lsu_gnt", 32'(lsu_gnt), 1);
    chk("b4_lsu_gnt_e", 32'(lsu_gnt_e), 1);
    tick(); lsu_req_i = 0;
    smp();
    chk("b4_waddr", 32'(waddr), 32'h13);
    chk("b4_sec", sec, 32'h0008_0000);
    chk("b4_waddr_e", 32'(waddr_e), 3);
    chk("b4_sec_e", sec_e, 32'h8);

    // Write to x0: granted, but no enable
    tick(); ex_req_i = 1; ex_addr_i = 0; ex_wdata_i = 32'hDEADBEEF;
    smp();
    chk("x0_ex_gnt", 32'(ex_gnt), 1);
    tick(); ex_req_i = 0;
    smp();
    chk("x0_we", 32'(we), 0);
    chk("x0_sec", sec, 0);

    // Full RV32I wipe with a simultaneous EX request held off until after DONE
    tick(); wipe_req_i = 1; ex_req_i = 1; ex_addr_i = 9; ex_wdata_i = 32'h99;
    smp();
    chk("w0_ex_gnt", 32'(ex_gnt), 0);
    chk("w0_lsu_gnt", 32'(lsu_gnt), 0);
    chk("w0_busy", 32'(busy), 0);
    dn = 0; bz = 0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 1)  wipe_req_i = 0;
      if (k == 34) ex_req_i = 0;
      smp();
      dn += int'(done); bz += int'(busy);
      chk($sformatf("w%0d_busy", k), 32'(busy), 32'(k <= 32));
      chk($sformatf("w%0d_done", k), 32'(done), 32'(k == 32));
      chk($sformatf("w%0d_ex_gnt", k), 32'(ex_gnt), 32'(k == 33));
      chk($sformatf("w%0d_we", k), 32'(we), 32'((k >= 2 && k <= 32) || k == 34));
      if (k >= 2 && k <= 32) begin
        oh = 32'd1 << (k - 1);
        chk($sformatf("w%0d_waddr", k), 32'(waddr), 32'(k - 1));
        chk($sformatf("w%0d_wdata", k), wdata, 0);
        chk($sformatf("w%0d_sec", k), sec, oh);
      end
      if (k == 34) begin
        chk("w34_waddr", 32'(waddr), 9);
        chk("w34_wdata", wdata, 32'h99);
      end
    end
    chk("w_done_cnt", 32'(dn), 1);
    chk("w_busy_cnt", 32'(bz), 32);

    // RV32E wipe: addresses 1..15 only
    tick(); wipe_req_i = 1;
    smp();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) wipe_req_i = 0;
      smp();
      chk($sformatf("e%0d_busy", k), 32'(busy_e), 32'(k <= 16));
      chk($sformatf("e%0d_done", k), 32'(done_e), 32'(k == 16));
      chk($sformatf("e%0d_we", k), 32'(we_e), 32'(k >= 2 && k <= 16));
      chk($sformatf("e%0d_sec_hi", k), 32'(sec_e[31:16]), 0);
      if (k >= 2 && k <= 16) begin
        oh = 32'd1 << (k - 1);
        chk($sformatf("e%0d_waddr", k), 32'(waddr_e), 32'(k - 1));
        chk($sformatf("e%0d_sec", k), sec_e, oh);
      end
    end
    for (int k = 0; k < 16; k++) tick();
    smp();
    chk("e_end_busy", 32'(busy), 0);

    // Reset in the middle of a wipe at counter 7
    tick(); wipe_req_i = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) wipe_req_i = 0;
    end
    rst_i = 1;
    smp();
    chk("rw_busy_pre", 32'(busy), 1);
    chk("rw_waddr_pre", 32'(waddr), 6);
    tick(); rst_i = 0;
    smp();
    chk("rw_busy", 32'(busy), 0);
    chk("rw_we", 32'(we), 0);
    chk("rw_sec", sec, 0);
    chk("rw_done", 32'(done), 0);
    dn = 0; bz = 0;
    for (int k = 0; k < 30; k++) begin
      tick(); smp();
      dn += int'(done) + int'(done_e);
      bz += int'(busy) + int'(busy_e);
    end
    chk("rw_no_done", 32'(dn), 0);
    chk("rw_no_busy", 32'(bz), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
